// File: rtl/eth_parser_pkg.sv
// Shared types and constants for the Ethernet II receive path.
package eth_parser_pkg;

    localparam int ETH_HDR_BYTES       = 14;
    localparam int ETH_MAX_FRAME_BYTES = 1518;

    // Element [0] holds the first byte received on the wire.
    typedef logic [ETH_HDR_BYTES-1:0][7:0] eth_header_bytes_t;

    typedef enum logic [1:0] {
        S_HDR,
        S_PAYLOAD,
        S_DROP,
        S_DONE
    } rx_seq_state_t;

endpackage

// File: rtl/eth_stat_counter.sv
// Statistics up-counter; SATURATE selects hold-at-all-ones instead of wrap.
module eth_stat_counter #(
    parameter int W        = 16,
    parameter bit SATURATE = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Count events, optionally sticking at full scale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && !(SATURATE && (&cnt))) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/eth_rx_frame_sequencer.sv
// Byte-serial RX sequencer: captures the Ethernet II header, hands it to the
// external decoder, then passes the payload straight through.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_HDR     | collecting header bytes; runt frames end here
// S_PAYLOAD | header frozen and valid; payload passes through unbuffered
// S_DROP    | oversize frame; discard input up to and including tlast
// S_DONE    | header-only frame completed; one cycle with header valid
module eth_rx_frame_sequencer
    import eth_parser_pkg::*;
#(
    parameter int HDR_BYTES       = ETH_HDR_BYTES,
    parameter int MAX_FRAME_BYTES = ETH_MAX_FRAME_BYTES,
    parameter int CNT_W           = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic              s_tlast,
    output eth_header_bytes_t header_bytes,
    output logic              header_valid,
    output logic [7:0]        m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic              frame_done,
    output logic              runt_err,
    output logic              oversize_err,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int BC_W = $clog2(MAX_FRAME_BYTES + 1);
    localparam int HI_W = $clog2(HDR_BYTES);
    localparam logic [BC_W-1:0] HDR_LAST = BC_W'(HDR_BYTES - 1);
    localparam logic [BC_W-1:0] MAX_LAST = BC_W'(MAX_FRAME_BYTES - 1);

    rx_seq_state_t   state_q, state_d;
    logic [BC_W-1:0] count_q, count_d;
    logic [HI_W-1:0] hdr_idx;
    logic            accept;
    logic            hdr_wr;
    logic            done_set, runt_set, over_set, done_now;
    logic            done_q, runt_q, over_q;

    assign accept  = s_tvalid & s_tready;
    assign hdr_idx = count_q[HI_W-1:0];

    // Next-state, handshake steering and event decode.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        s_tready     = 1'b0;
        m_tdata      = 8'h00;
        m_tvalid     = 1'b0;
        m_tlast      = 1'b0;
        header_valid = 1'b0;
        hdr_wr       = 1'b0;
        done_set     = 1'b0;
        runt_set     = 1'b0;
        over_set     = 1'b0;
        done_now     = 1'b0;
        case (state_q)
            S_HDR: begin
                s_tready = 1'b1;
                if (accept) begin
                    hdr_wr = 1'b1;
                    if (count_q == HDR_LAST) begin
                        count_d = count_q + 1'b1;
                        state_d = s_tlast ? S_DONE : S_PAYLOAD;
                    end else if (s_tlast) begin
                        runt_set = 1'b1;
                        count_d  = '0;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            S_PAYLOAD: begin
                header_valid = 1'b1;
                m_tdata      = s_tdata;
                m_tvalid     = s_tvalid;
                s_tready     = m_tready;
                // The byte that reaches the size limit closes the outgoing stream.
                m_tlast      = s_tlast || (count_q == MAX_LAST);
                if (accept) begin
                    if (s_tlast) begin
                        done_set = 1'b1;
                        count_d  = '0;
                        state_d  = S_HDR;
                    end else if (count_q == MAX_LAST) begin
                        over_set = 1'b1;
                        count_d  = '0;
                        state_d  = S_DROP;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            S_DROP: begin
                s_tready = 1'b1;
                if (accept && s_tlast) begin
                    state_d = S_HDR;
                end
            end
            S_DONE: begin
                header_valid = 1'b1;
                done_now     = 1'b1;
                count_d      = '0;
                state_d      = S_HDR;
            end
            default: begin
                state_d = S_HDR;
                count_d = '0;
            end
        endcase
    end

    // State, byte count and registered event pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_HDR;
            count_q <= '0;
            done_q  <= 1'b0;
            runt_q  <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_set;
            runt_q  <= runt_set;
            over_q  <= over_set;
        end
    end

    // Header capture; untouched outside S_HDR so the decoder sees a stable array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            header_bytes <= '0;
        end else if (hdr_wr) begin
            header_bytes[hdr_idx] <= s_tdata;
        end
    end

    assign frame_done   = done_q | done_now;
    assign runt_err     = runt_q;
    assign oversize_err = over_q;

    eth_stat_counter #(.W(CNT_W), .SATURATE(1'b0)) u_frame_cnt (
        .clk (clk),
        .rst (rst),
        .inc (frame_done),
        .cnt (frame_cnt)
    );

    eth_stat_counter #(.W(CNT_W), .SATURATE(1'b1)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (runt_q | over_q),
        .cnt (err_cnt)
    );

endmodule

// File: tb/tb_eth_rx_frame_sequencer.sv
// Scoreboard bench for eth_rx_frame_sequencer (built with a 64-byte size limit).
module tb_eth_rx_frame_sequencer;
    import eth_parser_pkg::*;

    localparam int MAXB  = 64;
    localparam int CNT_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        s_tdata = 8'h00;
    logic              s_tvalid = 1'b0;
    logic              s_tready;
    logic              s_tlast = 1'b0;
    eth_header_bytes_t header_bytes;
    logic              header_valid;
    logic [7:0]        m_tdata;
    logic              m_tvalid;
    logic              m_tready = 1'b1;
    logic              m_tlast;
    logic              frame_done, runt_err, oversize_err;
    logic [CNT_W-1:0]  frame_cnt, err_cnt;

    eth_rx_frame_sequencer #(.MAX_FRAME_BYTES(MAXB), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .header_bytes(header_bytes), .header_valid(header_valid),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .frame_done(frame_done), .runt_err(runt_err), .oversize_err(oversize_err),
        .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic [8:0] exp_q[$];
    logic [7:0] frm[$];
    eth_header_bytes_t exp_hdr = '0;
    int n_done, n_runt, n_over, n_hv, n_hv_done;
    int rise_cyc, acc13_cyc;
    logic prev_hv = 1'b0;
    int exp_frames = 0;
    int exp_errs = 0;
    int used;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Output monitor: payload scoreboard, header stability, pulse accounting.
    initial forever begin
        logic [8:0] e;
        @(negedge clk);
        if (m_tvalid && m_tready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL payload_unexpected: got tlast=%0b data=%02h, expected no beat", m_tlast, m_tdata);
            end else begin
                e = exp_q.pop_front();
                if ({m_tlast, m_tdata} !== e) begin
                    miscompares++;
                    $display("FAIL payload_beat: got tlast=%0b data=%02h, expected tlast=%0b data=%02h",
                             m_tlast, m_tdata, e[8], e[7:0]);
                end
            end
        end
        if (header_valid) begin
            vectors++;
            n_hv++;
            if (frame_done) n_hv_done++;
            if (header_bytes !== exp_hdr) begin
                miscompares++;
                $display("FAIL header_bytes: got %h, expected %h", header_bytes, exp_hdr);
            end
        end
        if (header_valid && !prev_hv) rise_cyc = cyc;
        prev_hv = header_valid;
        if (frame_done === 1'b1) n_done++;
        if (runt_err === 1'b1) n_runt++;
        if (oversize_err === 1'b1) n_over++;
        if ((32'(frame_done) + 32'(runt_err) + 32'(oversize_err)) > 1) begin
            miscompares++;
            $display("FAIL pulse_exclusive: got done=%0b runt=%0b over=%0b, expected at most one",
                     frame_done, runt_err, oversize_err);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic build(input int len, input logic [7:0] seed);
        logic [7:0] hdr[14];
        hdr = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h08, 8'h00};
        frm.delete();
        for (int i = 0; i < len; i++) frm.push_back(i < 14 ? hdr[i] : 8'(seed + 8'(i)));
        if (len >= 14) for (int i = 0; i < 14; i++) exp_hdr[i] = hdr[i];
    endtask

    task automatic push_payload(input int last, input int tlast_at);
        for (int i = 14; i <= last; i++) exp_q.push_back({i == tlast_at, frm[i]});
    endtask

    task automatic clr_stats();
        n_done = 0; n_runt = 0; n_over = 0; n_hv = 0; n_hv_done = 0;
        rise_cyc = -1; acc13_cyc = -100;
    endtask

    task automatic send(input int len, input int tlast_idx, input bit toggle, output int cycles);
        int idx = 0;
        cycles = 0;
        while (idx < len) begin
            @(posedge clk); #1;
            s_tvalid = 1'b1;
            s_tdata  = frm[idx];
            s_tlast  = (idx == tlast_idx);
            m_tready = toggle ? ~m_tready : 1'b1;
            @(negedge clk);
            cycles++;
            if (toggle && idx >= 14) begin
                vectors++;
                if (s_tready !== m_tready) begin
                    miscompares++;
                    $display("FAIL tready_mirror: got s_tready=%0b, expected %0b (byte %0d)", s_tready, m_tready, idx);
                end
            end
            if (s_tready) begin
                if (idx == 13) acc13_cyc = cyc;
                idx++;
            end
            if (cycles > len * 4 + 20) begin
                miscompares++;
                $display("FAIL send_timeout: got %0d bytes accepted, expected %0d", idx, len);
                break;
            end
        end
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_int(input string name, input int got, input int want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic check_common(input string tag);
        check_int({tag, "_frame_cnt"}, int'(frame_cnt), exp_frames);
        check_int({tag, "_err_cnt"}, int'(err_cnt), exp_errs);
        check_int({tag, "_queue_left"}, exp_q.size(), 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        vectors++;
        if ({header_valid, frame_done, runt_err, oversize_err, m_tvalid} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got hv=%0b done=%0b runt=%0b over=%0b mv=%0b, expected all 0",
                     header_valid, frame_done, runt_err, oversize_err, m_tvalid);
        end
        vectors++;
        if (header_bytes !== '0 || frame_cnt !== '0 || err_cnt !== '0 || s_tready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_state: got hdr=%h fc=%0d ec=%0d rdy=%0b, expected 0/0/0/1",
                     header_bytes, frame_cnt, err_cnt, s_tready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_good_frame(input string tag, input logic [7:0] seed);
        build(60, seed);
        push_payload(59, 59);
        clr_stats();
        send(60, 59, 1'b0, used);
        settle();
        exp_frames++;
        check_int({tag, "_hv_latency"}, rise_cyc, acc13_cyc + 1);
        check_int({tag, "_ethertype"}, int'({header_bytes[12], header_bytes[13]}), 32'h0800);
        check_int({tag, "_done_pulses"}, n_done, 1);
        check_int({tag, "_cycles"}, used, 60);
        check_common(tag);
    endtask

    task automatic test_runt();
        build(10, 8'h30);
        clr_stats();
        send(10, 9, 1'b0, used);
        settle();
        exp_errs++;
        check_int("runt_pulses", n_runt, 1);
        check_int("runt_hv_cycles", n_hv, 0);
        check_int("runt_done_pulses", n_done, 0);
        check_common("runt");
        test_good_frame("after_runt", 8'h40);
    endtask

    task automatic test_header_only();
        build(14, 8'h00);
        clr_stats();
        send(14, 13, 1'b0, used);
        settle();
        exp_frames++;
        check_int("hdr_only_hv_cycles", n_hv, 1);
        check_int("hdr_only_hv_with_done", n_hv_done, 1);
        check_int("hdr_only_done_pulses", n_done, 1);
        check_common("hdr_only");
    endtask

    task automatic test_oversize();
        build(70, 8'h80);
        push_payload(MAXB - 1, MAXB - 1);
        clr_stats();
        send(70, 69, 1'b0, used);
        settle();
        exp_errs++;
        check_int("oversize_pulses", n_over, 1);
        check_int("oversize_done_pulses", n_done, 0);
        check_int("oversize_cycles", used, 70);
        check_common("oversize");
    endtask

    task automatic test_exact_max();
        build(MAXB, 8'h90);
        push_payload(MAXB - 1, MAXB - 1);
        clr_stats();
        send(MAXB, MAXB - 1, 1'b0, used);
        settle();
        exp_frames++;
        check_int("exact_max_done", n_done, 1);
        check_int("exact_max_over", n_over, 0);
        check_common("exact_max");
    endtask

    task automatic test_back_to_back_backpressure();
        build(60, 8'hA0);
        push_payload(59, 59);
        clr_stats();
        send(60, 59, 1'b1, used);
        settle();
        exp_frames++;
        check_int("bp_done_pulses", n_done, 1);
        check_common("bp");
    endtask

    task automatic test_reset_mid_frame();
        build(60, 8'hC0);
        push_payload(43, -1);
        clr_stats();
        send(44, -1, 1'b0, used);
        s_tvalid = 1'b1;
        s_tdata  = 8'hAA;
        rst      = 1'b1;
        #1;
        vectors++;
        if ({header_valid, m_tvalid, frame_done, runt_err, oversize_err} !== 5'b0 || s_tready !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_flags: got hv=%0b mv=%0b done=%0b runt=%0b over=%0b rdy=%0b, expected 0s and rdy=1",
                     header_valid, m_tvalid, frame_done, runt_err, oversize_err, s_tready);
        end
        vectors++;
        if (header_bytes !== '0 || frame_cnt !== '0 || err_cnt !== '0) begin
            miscompares++;
            $display("FAIL midreset_state: got hdr=%h fc=%0d ec=%0d, expected all 0", header_bytes, frame_cnt, err_cnt);
        end
        s_tvalid = 1'b0;
        exp_frames = 0;
        exp_errs = 0;
        check_int("midreset_queue_left", exp_q.size(), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        test_good_frame("after_reset", 8'h20);
    endtask

    initial begin
        test_reset();
        test_good_frame("basic", 8'h10);
        test_runt();
        test_header_only();
        test_oversize();
        test_exact_max();
        test_back_to_back_backpressure();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/eth_rx_frame_sequencer.md
Name: eth_rx_frame_sequencer

Overview:
- Byte-serial receive front end that sequences the Ethernet II header decoder.
- Accepts a byte-wide valid/ready stream and captures the first 14 bytes of each frame into a header byte array.
- Presents that array with a header-valid qualifier to the combinational header decoder, then forwards the payload on a byte stream.
- Enforces runt and oversize frame limits and keeps frame statistics; sits between the MAC RX byte interface and the downstream classifier.

Parameters:
- HDR_BYTES, 14, header length in bytes; fixed by Ethernet II and not overridden.
- MAX_FRAME_BYTES, 1518, maximum accepted frame length in bytes, header included.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- s_tdata  in  8  input byte
- s_tvalid  in  1  input byte valid
- s_tready  out  1  input byte accepted when s_tvalid & s_tready
- s_tlast  in  1  last byte of frame
- header_bytes  out  HDR_BYTES*8  captured header; byte 0 is the first received byte
- header_valid  out  1  header_bytes complete and stable
- m_tdata  out  8  payload byte
- m_tvalid  out  1  payload byte valid
- m_tready  in  1  downstream ready
- m_tlast  out  1  last payload byte
- frame_done  out  1  one-cycle pulse, frame fully accepted
- runt_err  out  1  one-cycle pulse, frame ended before the header completed
- oversize_err  out  1  one-cycle pulse, frame exceeded MAX_FRAME_BYTES
- frame_cnt  out  CNT_W  good frames, wraps
- err_cnt  out  CNT_W  runt plus oversize frames, saturates at all-ones

Behaviour:
- Reset (async assert, sync release):
  - State S_HDR; byte count 0; header_bytes all 0.
  - header_valid, frame_done, runt_err, oversize_err = 0; both counters = 0.
  - Reset asserted mid-frame discards the frame. After release the next accepted byte is treated as byte 0.
- Byte count: width $clog2(MAX_FRAME_BYTES+1). Counts accepted input bytes of the current frame, header included. Cleared on every frame end.
- S_HDR:
  - s_tready=1; m_tvalid=0; header_valid=0.
  - Each accepted byte is stored at header_bytes[count] and count increments.
  - Accepted byte with s_tlast and count<13: runt_err pulses next cycle, err_cnt increments, count returns to 0, state stays S_HDR.
  - Accepted byte at count==13 without s_tlast: go to S_PAYLOAD; header_valid=1 from the next cycle.
  - Accepted byte at count==13 with s_tlast (header-only frame): go to S_DONE.
- S_PAYLOAD:
  - header_valid=1 and header_bytes frozen.
  - Combinational pass-through: m_tdata=s_tdata, m_tvalid=s_tvalid, s_tready=m_tready, m_tlast=s_tlast.
  - Accepted byte with s_tlast: frame_done pulses next cycle, frame_cnt increments, state returns to S_HDR (header_valid drops the same cycle).
  - Accepted byte that brings count to MAX_FRAME_BYTES without s_tlast:
    - That byte is forwarded with m_tlast forced to 1.
    - oversize_err pulses next cycle; err_cnt increments; go to S_DROP.
- S_DROP:
  - s_tready=1; m_tvalid=0; header_valid=0.
  - Bytes are discarded up to and including the s_tlast byte, then return to S_HDR.
  - No frame_done pulse; frame_cnt is not incremented.
- S_DONE (one cycle):
  - header_valid=1; s_tready=0; frame_done pulses the same cycle and frame_cnt increments.
  - Next state S_HDR.
- A frame that has exactly MAX_FRAME_BYTES bytes with s_tlast on the final byte is good, not oversize.
- Latency: header_valid rises 1 cycle after the 14th header byte is accepted. The payload path has zero latency and no buffering.
- frame_cnt wraps from all-ones to 0; err_cnt holds at all-ones.
- Only one of frame_done, runt_err, oversize_err can pulse in any cycle.

Decomposition:
- Use eth_parser_pkg::eth_header_bytes_t for header_bytes.
- Add to eth_parser_pkg: ETH_HDR_BYTES=14, ETH_MAX_FRAME_BYTES=1518, and the state enum type rx_seq_state_t (S_HDR, S_PAYLOAD, S_DROP, S_DONE).
- One natural sub-module: eth_stat_counter, an up counter with a wrap-or-saturate mode parameter, instantiated twice.
- The header decoder is instantiated by the parent, not inside this block.

Test Plan:
- 60-byte frame with dest FF:FF:FF:FF:FF:FF, src 00:11:22:33:44:55, ethertype 0x0800, m_tready=1 -> header_valid 1 cycle after byte 13; header_bytes[12..13]=08,00; 46 payload bytes out; m_tlast on the last; frame_done once; frame_cnt=1.
- 10-byte frame with s_tlast on byte 9 -> runt_err one pulse; err_cnt=1; no m_tvalid; the next 60-byte frame parses correctly from its byte 0.
- 14-byte header-only frame -> S_DONE; header_valid and frame_done high together for exactly 1 cycle; no m_tvalid.
- MAX_FRAME_BYTES=64 with a 70-byte frame -> byte 63 forwarded with m_tlast=1; oversize_err pulse; bytes 64..69 dropped with s_tready=1; frame_cnt unchanged.
- 60-byte frame with m_tready toggling 1/0 every cycle -> s_tready mirrors m_tready in S_PAYLOAD; no byte lost or duplicated; header_bytes stable throughout.
- Reset asserted at payload byte 30 -> all outputs at reset values immediately; after release a fresh 60-byte frame parses with count starting at 0.
